wb_arbiter2: RTL and testbench

WB_ARBITER2 -- requirements
Module: wb_arbiter2

---
 rtl/wb_arbiter2.sv | 128 ++++++++++++
 tb/tb_wb_arbiter2.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter2.sv
// Two-master Wishbone arbiter: instruction bridge (m0) and data bridge (m1)
// share one slave bus. A grant always passes through IDLE; a tie goes to the
// master that was not granted last. A strobe that stays unanswered for TIMEOUT
// cycles gets a one-cycle error pulse toward the owner.
module wb_arbiter2 #(
    parameter int TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    // master 0 (instruction bridge)
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_stb_i,
    input  logic        m0_cyc_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    // master 1 (data bridge)
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_stb_i,
    input  logic        m1_cyc_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    // shared slave bus
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic        s_stb_o,
    output logic        s_cyc_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        s_err_i
);

    localparam logic [7:0] TMO_VAL = 8'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
        logic [3:0]  sel;
        logic        stb;
        logic        cyc;
    } wb_req_t;

    state_t     state;
    logic       last;       // 0: m0 granted most recently, 1: m1
    logic [7:0] tmo_cnt;
    logic       stb_wait;
    logic       tmo_pulse;
    wb_req_t    m0_req, m1_req, s_req;

    assign m0_req = '{adr: m0_adr_i, dat: m0_dat_i, we: m0_we_i,
                      sel: m0_sel_i, stb: m0_stb_i, cyc: m0_cyc_i};
    assign m1_req = '{adr: m1_adr_i, dat: m1_dat_i, we: m1_we_i,
                      sel: m1_sel_i, stb: m1_stb_i, cyc: m1_cyc_i};

    // Slave-side request mux: owner passes straight through, IDLE drives zeros
    always_comb begin
        s_req = '0;
        case (state)
            GNT0:    s_req = m0_req;
            GNT1:    s_req = m1_req;
            default: s_req = '0;
        endcase
    end

    assign s_adr_o = s_req.adr;
    assign s_dat_o = s_req.dat;
    assign s_we_o  = s_req.we;
    assign s_sel_o = s_req.sel;
    assign s_stb_o = s_req.stb;
    assign s_cyc_o = s_req.cyc;

    // Compare uses the pre-increment count; an ack/err in the same cycle
    // clears the wait, so a timeout never coincides with a normal response.
    assign stb_wait  = s_stb_o & ~s_ack_i & ~s_err_i;
    assign tmo_pulse = stb_wait & (tmo_cnt == TMO_VAL);

    // Responses go to the owner only; suppressed while reset aborts the grant
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign m0_ack_o = (state == GNT0) & s_ack_i & ~wb_rst_i;
    assign m1_ack_o = (state == GNT1) & s_ack_i & ~wb_rst_i;
    assign m0_err_o = (state == GNT0) & (s_err_i | tmo_pulse) & ~wb_rst_i;
    assign m1_err_o = (state == GNT1) & (s_err_i | tmo_pulse) & ~wb_rst_i;

    // Unanswered-strobe counter; restarts after each timeout pulse
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || !stb_wait || tmo_pulse)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + 8'd1;
    end

    // Grant FSM: no pre-emption, release always returns through IDLE
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_cyc_i && (!m1_cyc_i || last)) begin
                        state <= GNT0;
                        last  <= 1'b0;
                    end else if (m1_cyc_i) begin
                        state <= GNT1;
                        last  <= 1'b1;
                    end
                end
                GNT0:    if (!m0_cyc_i) state <= IDLE;
                GNT1:    if (!m1_cyc_i) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2 (TIMEOUT=4): reset, single read, tie
// alternation, write passthrough, timeout, reset mid-op, slave error.
module tb_wb_arbiter2;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i, s_dat_i;
    logic        m0_we_i, m0_stb_i, m0_cyc_i, m1_we_i, m1_stb_i, m1_cyc_i;
    logic [3:0]  m0_sel_i, m1_sel_i;
    logic        s_ack_i, s_err_i;
    logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
    logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic        s_we_o, s_stb_o, s_cyc_o;
    logic [3:0]  s_sel_o;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] ADR_A = 32'h0000_0100;
    localparam logic [31:0] ADR_B = 32'h0000_2000;

    wb_arbiter2 #(.TIMEOUT(4)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_we_i(m0_we_i),
        .m0_sel_i(m0_sel_i), .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_we_i(m1_we_i),
        .m1_sel_i(m1_sel_i), .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o),
        .s_sel_o(s_sel_o), .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic step();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        wb_rst_i = 1'b1;
        m0_adr_i = ADR_A; m0_dat_i = '0; m0_we_i = 0; m0_sel_i = 4'hF; m0_stb_i = 1; m0_cyc_i = 1;
        m1_adr_i = ADR_B; m1_dat_i = '0; m1_we_i = 0; m1_sel_i = 4'hF; m1_stb_i = 0; m1_cyc_i = 0;
        s_dat_i = '0; s_ack_i = 1; s_err_i = 1;

        // Reset: bus quiet and no responses even with the slave driving ack/err
        step(); step(); #1;
        chk("rst_s_cyc", s_cyc_o, 0);
        chk("rst_s_stb", s_stb_o, 0);
        chk("rst_m0_ack", m0_ack_o, 0);
        chk("rst_m0_err", m0_err_o, 0);
        m0_stb_i = 0; m0_cyc_i = 0; s_ack_i = 0; s_err_i = 0;
        wb_rst_i = 0;

        // Single read by m0
        step(); m0_cyc_i = 1; m0_stb_i = 1; #1;
        chk("rd_idle_s_cyc", s_cyc_o, 0);
        step(); #1;
        chk("rd_gnt_s_cyc", s_cyc_o, 1);
        chk("rd_gnt_s_adr", s_adr_o, ADR_A);
        chk("rd_early_ack", m0_ack_o, 0);
        step();
        step(); s_ack_i = 1; s_dat_i = 32'hDEAD_BEEF; #1;
        chk("rd_m0_ack", m0_ack_o, 1);
        chk("rd_m0_dat", m0_dat_o, 32'hDEAD_BEEF);
        chk("rd_m1_ack", m1_ack_o, 0);
        chk("rd_m1_dat", m1_dat_o, 32'hDEAD_BEEF);
        step(); s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0; #1;
        chk("rd_ack_one_cycle", m0_ack_o, 0);
        step(); #1;
        chk("rd_idle_after", s_cyc_o, 0);

        // Tie after reset: m0 first, m1 two cycles after release, m0 again
        wb_rst_i = 1; step(); wb_rst_i = 0;
        m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1; #1;
        chk("tie_idle", s_cyc_o, 0);
        step(); s_ack_i = 1; #1;
        chk("tie1_adr_m0", s_adr_o, ADR_A);
        chk("tie1_m0_ack", m0_ack_o, 1);
        chk("tie1_m1_ack", m1_ack_o, 0);
        step(); s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0; #1;
        chk("tie_release_cyc", s_cyc_o, 0);
        step(); #1;
        chk("tie_pass_idle", s_cyc_o, 0);
        step(); #1;
        chk("tie_m1_gnt_cyc", s_cyc_o, 1);
        chk("tie_m1_gnt_adr", s_adr_o, ADR_B);
        m1_cyc_i = 0; m1_stb_i = 0;
        step(); m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
        step(); #1;
        chk("tie2_adr_m0", s_adr_o, ADR_A);
        m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        step(); step();

        // Write passthrough by m1
        m1_adr_i = 32'h0000_1000; m1_dat_i = 32'h1234_5678; m1_sel_i = 4'b0011;
        m1_we_i = 1; m1_cyc_i = 1; m1_stb_i = 1; #1;
        chk("wr_idle_we", s_we_o, 0);
        chk("wr_idle_adr", s_adr_o, 0);
        step(); s_ack_i = 1; #1;
        chk("wr_adr", s_adr_o, 32'h0000_1000);
        chk("wr_dat", s_dat_o, 32'h1234_5678);
        chk("wr_sel", s_sel_o, 4'b0011);
        chk("wr_we", s_we_o, 1);
        chk("wr_m1_ack", m1_ack_o, 1);
        chk("wr_m0_ack", m0_ack_o, 0);
        step(); s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0; #1;
        step(); #1;
        chk("wr_after_we", s_we_o, 0);
        chk("wr_after_dat", s_dat_o, 0);
        chk("wr_after_sel", s_sel_o, 0);
        m1_we_i = 0; m1_adr_i = ADR_B; m1_sel_i = 4'hF;

        // Timeout: error on the 5th unanswered strobe cycle, one cycle only
        m1_cyc_i = 1; m1_stb_i = 1;
        step(); #1;
        chk("tmo_stb_rise", s_stb_o, 1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("tmo_wait%0d", i), m1_err_o, 0);
            step(); #1;
        end
        chk("tmo_m1_err", m1_err_o, 1);
        chk("tmo_m0_err", m0_err_o, 0);
        step(); m0_cyc_i = 1; m0_stb_i = 1; #1;
        chk("tmo_err_once", m1_err_o, 0);
        chk("tmo_hold_adr", s_adr_o, ADR_B);
        chk("tmo_hold_cyc", s_cyc_o, 1);
        step(); m1_cyc_i = 0; m1_stb_i = 0; #1;
        chk("abandon_no_err", m1_err_o, 0);
        step(); #1;
        chk("tmo_idle", s_cyc_o, 0);
        step(); #1;
        chk("tmo_m0_gnt", s_adr_o, ADR_A);
        m0_cyc_i = 0; m0_stb_i = 0;
        step(); step();

        // Reset mid-transfer in GNT1 with the slave acking
        m1_cyc_i = 1; m1_stb_i = 1;
        step(); s_ack_i = 1; #1;
        chk("rmid_pre_ack", m1_ack_o, 1);
        wb_rst_i = 1; #1;
        chk("rmid_abort_ack", m1_ack_o, 0);
        step(); wb_rst_i = 0; #1;
        chk("rmid_next_ack", m1_ack_o, 0);
        chk("rmid_next_cyc", s_cyc_o, 0);
        m1_cyc_i = 0; m1_stb_i = 0; s_ack_i = 0;
        step(); step();

        // Slave error during an m0 transfer
        m0_cyc_i = 1; m0_stb_i = 1; s_err_i = 1; #1;
        chk("serr_idle", m0_err_o, 0);
        step(); m1_cyc_i = 1; m1_stb_i = 1; #1;
        chk("serr_m0_err", m0_err_o, 1);
        chk("serr_m1_err", m1_err_o, 0);
        chk("serr_m0_ack", m0_ack_o, 0);
        step(); s_err_i = 0; #1;
        chk("serr_drop", m0_err_o, 0);
        m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
